// File: rtl/i2c_pkg.sv
// i2c_pkg: command encodings shared by the I2C byte-level master and the
// blocks that drive its cmd/stb/ready interface.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } i2c_cmd_e;

endpackage

// File: rtl/i2c_reg_xfer.sv
// i2c_reg_xfer: expands one register read/write request into the
// START/WRITE/READ/STOP primitive sequence of the I2C byte master and folds
// the per-step ACK, read data and timeout status into one response pulse.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_rw/dev/reg/wdata       request fields (latched on acceptance)
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata/nak/err          response fields, held until the next response
//   mst_cmd/data/ack/stb       command interface toward the master
//   mst_ready/rdata/ack_out/err status from the master
module i2c_reg_xfer
  import i2c_pkg::*;
#(
  parameter bit RESTART = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nak,
  output logic       rsp_err,
  output logic [1:0] mst_cmd,
  output logic [7:0] mst_data,
  output logic       mst_ack,
  output logic       mst_stb,
  input  logic       mst_ready,
  input  logic [7:0] mst_rdata,
  input  logic       mst_ack_out,
  input  logic       mst_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       nak_q;
  logic       err_q;

  // Index of the closing STOP; every abort jumps straight to it.
  function automatic logic [2:0] last_step(input logic rw);
    if (!rw)          return 3'd4;
    else if (RESTART) return 3'd6;
    else              return 3'd7;
  endfunction

  // Step index -> {cmd, data}. START/STOP/READ carry a zero data byte.
  function automatic logic [9:0] step_map(input logic [2:0] step, input logic rw,
                                          input logic [6:0] dev, input logic [7:0] regaddr,
                                          input logic [7:0] wdata);
    logic [1:0] cmd;
    logic [7:0] data;
    cmd  = CMD_STOP;
    data = 8'h00;
    case (step)
      3'd0: cmd = CMD_START;
      3'd1: begin cmd = CMD_WRITE; data = {dev, 1'b0}; end
      3'd2: begin cmd = CMD_WRITE; data = regaddr; end
      default: begin
        if (!rw) begin
          if (step == 3'd3) begin cmd = CMD_WRITE; data = wdata; end
        end else if (RESTART) begin
          // Repeated START directly after the register byte.
          case (step)
            3'd3:    cmd = CMD_START;
            3'd4:    begin cmd = CMD_WRITE; data = {dev, 1'b1}; end
            3'd5:    cmd = CMD_READ;
            default: cmd = CMD_STOP;
          endcase
        end else begin
          // STOP at step 3 closes the write phase before a fresh START.
          case (step)
            3'd4:    cmd = CMD_START;
            3'd5:    begin cmd = CMD_WRITE; data = {dev, 1'b1}; end
            3'd6:    cmd = CMD_READ;
            default: cmd = CMD_STOP;
          endcase
        end
      end
    endcase
    return {cmd, data};
  endfunction

  logic       accept;
  logic       wait_done;
  logic       at_last;
  logic       abort;
  logic [2:0] step_nxt;

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign wait_done = (state_q == ST_WAIT) && mst_ready;
  assign at_last   = (step_q == last_step(rw_q));
  assign abort     = mst_err || ((mst_cmd == CMD_WRITE) && mst_ack_out);
  assign step_nxt  = abort ? last_step(rw_q) : step_q + 3'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (mst_ready) state_d = ST_GUARD;
      // The master drops ready only the cycle after stb, so skip one cycle.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT:  if (mst_ready) state_d = at_last ? ST_RESP : ST_ISSUE;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mst_stb   = (state_q == ST_ISSUE) && mst_ready;
    rsp_valid = (state_q == ST_RESP);
  end

  // Request latch, step sequencing, status collection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q    <= 3'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      nak_q     <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nak   <= 1'b0;
      rsp_err   <= 1'b0;
      mst_cmd   <= CMD_STOP;
      mst_data  <= 8'h00;
      mst_ack   <= 1'b1;
    end else begin
      mst_ack <= 1'b1;
      if (accept) begin
        rw_q               <= req_rw;
        dev_q              <= req_dev;
        reg_q              <= req_reg;
        wdata_q            <= req_wdata;
        step_q             <= 3'd0;
        rdata_q            <= 8'h00;
        nak_q              <= 1'b0;
        err_q              <= 1'b0;
        {mst_cmd, mst_data} <= step_map(3'd0, req_rw, req_dev, req_reg, req_wdata);
      end
      if (wait_done) begin
        if (mst_err)                                    err_q   <= 1'b1;
        else if ((mst_cmd == CMD_WRITE) && mst_ack_out) nak_q   <= 1'b1;
        else if (mst_cmd == CMD_READ)                   rdata_q <= mst_rdata;
        if (at_last) begin
          rsp_rdata <= rdata_q;
          rsp_nak   <= nak_q;
          rsp_err   <= err_q | mst_err;
        end else begin
          step_q              <= step_nxt;
          {mst_cmd, mst_data} <= step_map(step_nxt, rw_q, dev_q, reg_q, wdata_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_xfer.sv
// tb_i2c_reg_xfer: directed bench for i2c_reg_xfer. Two instances (repeated
// START and STOP+START read variants) share one behavioural master/slave
// model through a select mux; bus command logs are compared against
// hand-written sequences.
`timescale 1ns/1ps
module tb_i2c_reg_xfer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       mst_ready, mst_ack_out, mst_err;
  logic [7:0] mst_rdata;

  logic       req_ready, rsp_valid, rsp_nak, rsp_err, mst_ack, mst_stb;
  logic [7:0] rsp_rdata, mst_data;
  logic [1:0] mst_cmd;

  logic       rdy_a, rv_a, nak_a, err_a, ack_a, stb_a;
  logic       rdy_b, rv_b, nak_b, err_b, ack_b, stb_b;
  logic [7:0] rd_a, dat_a, rd_b, dat_b;
  logic [1:0] cmd_a, cmd_b;

  always #5 clk = ~clk;

  i2c_reg_xfer #(.RESTART(1'b1)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_nak(nak_a), .rsp_err(err_a),
    .mst_cmd(cmd_a), .mst_data(dat_a), .mst_ack(ack_a), .mst_stb(stb_a),
    .mst_ready(mst_ready & ~sel), .mst_rdata(mst_rdata),
    .mst_ack_out(mst_ack_out), .mst_err(mst_err)
  );

  i2c_reg_xfer #(.RESTART(1'b0)) u_dut_r0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_nak(nak_b), .rsp_err(err_b),
    .mst_cmd(cmd_b), .mst_data(dat_b), .mst_ack(ack_b), .mst_stb(stb_b),
    .mst_ready(mst_ready & sel), .mst_rdata(mst_rdata),
    .mst_ack_out(mst_ack_out), .mst_err(mst_err)
  );

  assign req_ready = sel ? rdy_b : rdy_a;
  assign rsp_valid = sel ? rv_b  : rv_a;
  assign rsp_rdata = sel ? rd_b  : rd_a;
  assign rsp_nak   = sel ? nak_b : nak_a;
  assign rsp_err   = sel ? err_b : err_a;
  assign mst_cmd   = sel ? cmd_b : cmd_a;
  assign mst_data  = sel ? dat_b : dat_a;
  assign mst_ack   = sel ? ack_b : ack_a;
  assign mst_stb   = sel ? stb_b : stb_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Master/slave model knobs
  logic       nak_en = 1'b0;
  logic [7:0] nak_byte = 8'h00;
  logic       err_en = 1'b0;
  logic [7:0] err_byte = 8'h00;
  logic [7:0] rd_byte = 8'h5C;

  int         cyc = 0;
  int         log_n = 0;
  int         rsp_cnt = 0;
  int         acc_cyc = 0;
  int         rsp_cyc = 0;
  int         busy_cnt = 0;
  logic [9:0] log_key [64];
  logic       log_ack [64];
  int         stb_cyc [64];
  int         rise_cyc [64];
  logic       stb_prev = 1'b0;

  // Behavioural master: ready drops after each strobe for three cycles,
  // then returns with the slave's ACK/data and the timeout flag.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
    end
    if (req_valid && req_ready) acc_cyc <= cyc;
    if (!rst_n) begin
      mst_ready   <= 1'b1;
      busy_cnt    <= 0;
      mst_err     <= 1'b0;
      mst_ack_out <= 1'b0;
      mst_rdata   <= 8'h00;
    end else if (mst_stb && mst_ready) begin
      log_key[log_n % 64]  <= (mst_cmd == 2'b10) ? {mst_cmd, mst_data} : {mst_cmd, 8'h00};
      log_ack[log_n % 64]  <= mst_ack;
      stb_cyc[log_n % 64]  <= cyc;
      log_n                <= log_n + 1;
      mst_ready            <= 1'b0;
      busy_cnt             <= 3;
      mst_ack_out          <= (mst_cmd == 2'b10) && nak_en && (mst_data == nak_byte);
      mst_rdata            <= (mst_cmd == 2'b11) ? rd_byte : 8'h00;
      mst_err              <= err_en && (mst_err || ((mst_cmd == 2'b10) && (mst_data == err_byte)));
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        mst_ready                   <= 1'b1;
        rise_cyc[(log_n - 1) % 64]  <= cyc;
      end
    end
  end

  // Protocol checker
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_stb) begin
        check_val("stb_while_ready", mst_ready, 1'b1);
        check_val("stb_not_back2back", stb_prev, 1'b0);
      end
      stb_prev <= mst_stb;
    end else begin
      stb_prev <= 1'b0;
    end
  end

  logic [9:0] exp_log [8];

  task automatic check_log(input string tag, input int base, input int n_exp);
    check_val({tag, "_len"}, log_n - base, n_exp);
    for (int i = 0; i < n_exp; i++)
      check_val($sformatf("%s_step%0d", tag, i), log_key[(base + i) % 64], exp_log[i]);
  endtask

  task automatic run_req(input string tag, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd,
                         input int n_exp, input logic [7:0] e_rd,
                         input logic e_nak, input logic e_err);
    int   base, rsp0, last;
    logic got;
    logic [7:0] c_rd;
    logic c_nak, c_err;
    base = log_n;
    rsp0 = rsp_cnt;
    got  = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_rw = ~rw; req_dev = 7'h7F; req_reg = 8'hFF; req_wdata = 8'hFF;
    @(negedge clk);
    check_val({tag, "_rdy_busy"}, req_ready, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_val({tag, "_rsp_seen"}, got, 1'b1);
    c_rd = rsp_rdata; c_nak = rsp_nak; c_err = rsp_err;
    check_val({tag, "_rdata"}, c_rd, e_rd);
    check_val({tag, "_nak"}, c_nak, e_nak);
    check_val({tag, "_err"}, c_err, e_err);
    check_val({tag, "_rdy_in_rsp"}, req_ready, 1'b0);
    @(negedge clk);
    check_val({tag, "_rdy_after"}, req_ready, 1'b1);
    check_val({tag, "_rdata_held"}, rsp_rdata, e_rd);
    repeat (4) @(negedge clk);
    check_val({tag, "_one_pulse"}, rsp_cnt - rsp0, 1);
    check_log(tag, base, n_exp);
    last = base + n_exp - 1;
    check_val({tag, "_acc2stb"}, stb_cyc[base % 64] - acc_cyc, 1);
    check_val({tag, "_rdy2stb"}, stb_cyc[(base + 1) % 64] - rise_cyc[base % 64], 2);
    check_val({tag, "_stop2rsp"}, rsp_cyc - rise_cyc[last % 64], 2);
  endtask

  initial begin
    int base, rsp0;
    logic hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_req_ready", req_ready, 1'b1);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_rsp_nak", rsp_nak, 1'b0);
    check_val("rst_rsp_err", rsp_err, 1'b0);
    check_val("rst_rsp_rdata", rsp_rdata, 8'h00);
    check_val("rst_mst_stb", mst_stb, 1'b0);
    check_val("rst_mst_cmd", mst_cmd, 2'b01);
    check_val("rst_mst_data", mst_data, 8'h00);
    check_val("rst_mst_ack", mst_ack, 1'b1);

    // Write 0x50/0x12 <- 0xA5
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h212;
    exp_log[3] = 10'h2A5; exp_log[4] = 10'h100;
    run_req("wr", 1'b0, 7'h50, 8'h12, 8'hA5, 5, 8'h00, 1'b0, 1'b0);

    // Read with repeated START
    base = log_n;
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h234;
    exp_log[3] = 10'h000; exp_log[4] = 10'h2A1; exp_log[5] = 10'h300;
    exp_log[6] = 10'h100;
    run_req("rd_rs", 1'b1, 7'h50, 8'h34, 8'h00, 7, 8'h5C, 1'b0, 1'b0);
    check_val("rd_rs_read_nak", log_ack[(base + 5) % 64], 1'b1);

    // Read with STOP + START
    sel = 1'b1;
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h234;
    exp_log[3] = 10'h100; exp_log[4] = 10'h000; exp_log[5] = 10'h2A1;
    exp_log[6] = 10'h300; exp_log[7] = 10'h100;
    run_req("rd_ss", 1'b1, 7'h50, 8'h34, 8'h00, 8, 8'h5C, 1'b0, 1'b0);
    sel = 1'b0;

    // Slave NAKs the address byte
    nak_en = 1'b1; nak_byte = 8'hA0;
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h100;
    run_req("nak", 1'b0, 7'h50, 8'h12, 8'hA5, 3, 8'h00, 1'b1, 1'b0);
    nak_en = 1'b0;

    // Read aborted by NAK keeps rdata at zero
    nak_en = 1'b1; nak_byte = 8'h34;
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h234;
    exp_log[3] = 10'h100;
    run_req("rd_nak", 1'b1, 7'h50, 8'h34, 8'h00, 4, 8'h00, 1'b1, 1'b0);
    nak_en = 1'b0;

    // Master timeout held from the register byte onward
    err_en = 1'b1; err_byte = 8'h12;
    exp_log[0] = 10'h000; exp_log[1] = 10'h2A0; exp_log[2] = 10'h212;
    exp_log[3] = 10'h100;
    run_req("err", 1'b0, 7'h50, 8'h12, 8'hA5, 4, 8'h00, 1'b0, 1'b1);
    err_en = 1'b0;

    // Reset during the third step
    base = log_n;
    rsp0 = rsp_cnt;
    hit  = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h12; req_wdata = 8'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (log_n - base >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("mid_rst_third_step", hit, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("mid_rst_req_ready", req_ready, 1'b1);
    check_val("mid_rst_mst_cmd", mst_cmd, 2'b01);
    repeat (12) @(negedge clk);
    check_val("mid_rst_no_rsp", rsp_cnt - rsp0, 0);
    check_val("mid_rst_no_stb", log_n - base, 3);

    // Recovery after reset
    exp_log[0] = 10'h000; exp_log[1] = 10'h2C6; exp_log[2] = 10'h2F0;
    exp_log[3] = 10'h20F; exp_log[4] = 10'h100;
    run_req("wr2", 1'b0, 7'h63, 8'hF0, 8'h0F, 5, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
